// File: rtl/vreg_queue_pkg.sv
// Shared sizing helpers and line-trace string helpers for the vreg input queue.
package vreg_queue_pkg;

    function automatic int ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A fired port shows its message; a stalled one "#", an idle one ".", padded to the message width.
    function automatic string trace_port(input logic val, input logic rdy, input string msg);
        string s;
        if (val && rdy) begin
            return msg;
        end
        s = val ? "#" : ".";
        while (s.len() < msg.len()) begin
            s = {s, " "};
        end
        return s;
    endfunction

    function automatic string line_trace(input logic enq_val, input logic enq_rdy, input string enq_str,
                                         input int count, input logic deq_val, input logic deq_rdy,
                                         input string deq_str);
        return $sformatf("%s (%2d) %s", trace_port(enq_val, enq_rdy, enq_str), count,
                         trace_port(deq_val, deq_rdy, deq_str));
    endfunction

endpackage

// File: rtl/vreg_input_queue_if.sv
// Enqueue/dequeue handshake bundle of the vreg input queue.
interface vreg_input_queue_if
    import vreg_queue_pkg::*;
#(
    parameter int p_nbits       = 32,
    parameter int p_num_entries = 2
);
    localparam int c_cnt_w = cnt_width(p_num_entries);

    logic               enq_val;
    logic               enq_rdy;
    logic [p_nbits-1:0] enq_msg;
    logic               deq_val;
    logic               deq_rdy;
    logic [p_nbits-1:0] deq_msg;
    logic [c_cnt_w-1:0] count;

    modport master (
        output enq_val, enq_msg, deq_rdy,
        input  enq_rdy, deq_val, deq_msg, count
    );

    modport slave (
        input  enq_val, enq_msg, deq_rdy,
        output enq_rdy, deq_val, deq_msg, count
    );

endinterface

// File: rtl/vreg_queue_regfile.sv
// Queue storage: one synchronous write port, one combinational read port, no reset.
module vreg_queue_regfile
    import vreg_queue_pkg::*;
#(
    parameter int  p_nbits       = 32,
    parameter int  p_num_entries = 2,
    localparam int c_addr_w      = ptr_width(p_num_entries)
) (
    input  logic                clk,
    input  logic                wen,
    input  logic [c_addr_w-1:0] waddr,
    input  logic [p_nbits-1:0]  wdata,
    input  logic [c_addr_w-1:0] raddr,
    output logic [p_nbits-1:0]  rdata
);

    logic [p_nbits-1:0] mem [p_num_entries];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vreg_input_queue.sv
// Normal (non-bypass, non-pipe) val/rdy queue feeding the register stage's d input.
module vreg_input_queue
    import vreg_queue_pkg::*;
#(
    parameter int p_nbits       = 32,
    parameter int p_num_entries = 2
) (
    input logic               clk,
    input logic               reset,
    vreg_input_queue_if.slave q
);

    localparam int c_ptr_w = ptr_width(p_num_entries);
    localparam int c_cnt_w = cnt_width(p_num_entries);
    localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(p_num_entries - 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(p_num_entries);

    logic [c_ptr_w-1:0] head;
    logic [c_ptr_w-1:0] tail;
    logic [c_cnt_w-1:0] count;
    logic               enq_rdy;
    logic               deq_val;
    logic               enq_fire;
    logic               deq_fire;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [c_ptr_w-1:0] ptr_next(input logic [c_ptr_w-1:0] p);
        return (p == c_last) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign enq_rdy  = (count != c_full);
    assign deq_val  = (count != '0);
    assign enq_fire = q.enq_val && enq_rdy && !reset;
    assign deq_fire = q.deq_rdy && deq_val && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) begin
                tail <= ptr_next(tail);
            end
            if (deq_fire) begin
                head <= ptr_next(head);
            end
            if (enq_fire && !deq_fire) begin
                count <= count + c_cnt_w'(1);
            end else if (deq_fire && !enq_fire) begin
                count <= count - c_cnt_w'(1);
            end
        end
    end

    vreg_queue_regfile #(
        .p_nbits       (p_nbits),
        .p_num_entries (p_num_entries)
    ) regfile (
        .clk   (clk),
        .wen   (enq_fire),
        .waddr (tail),
        .wdata (q.enq_msg),
        .raddr (head),
        .rdata (q.deq_msg)
    );

    assign q.enq_rdy = enq_rdy;
    assign q.deq_val = deq_val;
    assign q.count   = count;

    a_count_max: assert property (@(posedge clk) disable iff (reset) count <= c_full);
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(deq_fire && !enq_fire && count == '0));
    a_head_range: assert property (@(posedge clk) disable iff (reset) int'(head) < p_num_entries);
    a_tail_range: assert property (@(posedge clk) disable iff (reset) int'(tail) < p_num_entries);

endmodule

// File: tb/tb_vreg_input_queue.sv
// Scoreboard bench driving a depth-2 and a depth-3 queue against a queue-based reference model.
module tb_vreg_input_queue;
    import vreg_queue_pkg::*;

    typedef logic [31:0] mq_t [$];

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   model_ok;
    bit   trace_on;
    bit   acc2;
    bit   acc3;
    mq_t  exp2;
    mq_t  exp3;

    vreg_input_queue_if #(.p_nbits(32), .p_num_entries(2)) q2 ();
    vreg_input_queue_if #(.p_nbits(32), .p_num_entries(3)) q3 ();

    vreg_input_queue #(.p_nbits(32), .p_num_entries(2)) dut2 (.clk(clk), .reset(rst), .q(q2));
    vreg_input_queue #(.p_nbits(32), .p_num_entries(3)) dut3 (.clk(clk), .reset(rst), .q(q3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Compare the current outputs with the model, then advance the model by this cycle's handshakes.
    task automatic checkOutput(input string tag, input int depth, input logic [31:0] cnt,
                               input logic er, input logic dv, input logic [31:0] dm,
                               input logic ev, input logic [31:0] em, input logic dr,
                               input logic rs, ref mq_t exp, output bit acc);
        int sz;
        sz  = exp.size();
        acc = 1'b0;
        if (model_ok) begin
            checkOne({tag, " count"}, cnt, 32'(sz));
            checkOne({tag, " enq_rdy"}, {31'b0, er}, {31'b0, sz != depth});
            checkOne({tag, " deq_val"}, {31'b0, dv}, {31'b0, sz != 0});
            if (sz != 0) begin
                checkOne({tag, " deq_msg"}, dm, exp[0]);
            end
        end
        if (rs) begin
            exp.delete();
        end else begin
            if (dr && sz > 0) begin
                void'(exp.pop_front());
            end
            if (ev && sz < depth) begin
                exp.push_back(em);
                acc = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (trace_on) begin
            $display("[TB] %s", line_trace(q3.enq_val, q3.enq_rdy, $sformatf("%08h", q3.enq_msg),
                     int'(q3.count), q3.deq_val, q3.deq_rdy, $sformatf("%08h", q3.deq_msg)));
        end
        checkOutput("d2", 2, 32'(q2.count), q2.enq_rdy, q2.deq_val, q2.deq_msg,
                    q2.enq_val, q2.enq_msg, q2.deq_rdy, rst, exp2, acc2);
        checkOutput("d3", 3, 32'(q3.count), q3.enq_rdy, q3.deq_val, q3.deq_msg,
                    q3.enq_val, q3.enq_msg, q3.deq_rdy, rst, exp3, acc3);
        if (rst) begin
            model_ok = 1'b1;
        end
    end

    task automatic applyStimulus(input bit rs, input bit e2, input logic [31:0] m2,
                                 input bit e3, input logic [31:0] m3, input bit dr);
        @(posedge clk);
        #1;
        rst        = rs;
        q2.enq_val = e2;
        q2.enq_msg = m2;
        q3.enq_val = e3;
        q3.enq_msg = m3;
        q2.deq_rdy = dr;
        q3.deq_rdy = dr;
    endtask

    task automatic both(input bit ev, input logic [31:0] msg, input bit dr);
        applyStimulus(1'b0, ev, msg, ev, msg, dr);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int i2;
        int i3;
        int guard;
        bit tog;
        checks     = 0;
        errors     = 0;
        model_ok   = 1'b0;
        trace_on   = 1'b1;
        rst        = 1'b1;
        q2.enq_val = 1'b0;
        q2.enq_msg = '0;
        q2.deq_rdy = 1'b0;
        q3.enq_val = 1'b0;
        q3.enq_msg = '0;
        q3.deq_rdy = 1'b0;

        // Reset then idle.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (3) both(1'b0, 32'h0, 1'b0);

        // Single transfer.
        both(1'b1, 32'h0000_00AB, 1'b0);
        both(1'b0, 32'h0, 1'b0);
        both(1'b0, 32'h0, 1'b1);
        both(1'b0, 32'h0, 1'b0);

        // Fill and block, then drain.
        both(1'b1, 32'h1, 1'b0);
        both(1'b1, 32'h2, 1'b0);
        both(1'b1, 32'h3, 1'b0);
        both(1'b1, 32'h4, 1'b0);
        repeat (4) both(1'b0, 32'h0, 1'b1);
        both(1'b0, 32'h0, 1'b0);

        // Simultaneous enqueue and dequeue at occupancy one.
        both(1'b1, 32'h10, 1'b0);
        both(1'b1, 32'h11, 1'b1);
        both(1'b0, 32'h0, 1'b0);
        both(1'b0, 32'h0, 1'b1);
        both(1'b0, 32'h0, 1'b0);

        // Wrap-around stream, each producer holding its message until accepted.
        i2    = 0;
        i3    = 0;
        guard = 0;
        tog   = 1'b0;
        while ((i2 < 10 || i3 < 10) && guard < 200) begin
            applyStimulus(1'b0, i2 < 10, 32'h20 + 32'(i2), i3 < 10, 32'h20 + 32'(i3), tog);
            @(negedge clk);
            #1;
            if (acc2) i2++;
            if (acc3) i3++;
            tog = !tog;
            guard++;
        end
        checkOne("wrap_progress", 32'(i2 + i3), 32'd20);
        repeat (5) both(1'b0, 32'h0, 1'b1);

        // Reset in the middle of operation.
        both(1'b1, 32'h40, 1'b0);
        both(1'b1, 32'h41, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h55, 1'b1, 32'h55, 1'b0);
        both(1'b1, 32'h66, 1'b0);
        both(1'b0, 32'h0, 1'b1);
        both(1'b0, 32'h0, 1'b0);
        trace_on = 1'b0;

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 59) == 0, bit'($urandom_range(0, 1)), $urandom,
                          bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)));
        end

        repeat (5) both(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
